// File: rtl/load_align_unit.sv
// Memory-phase load unit: one outstanding load, word-aligned dmem reads, result aligned and extended.
// Optional feature macro: MISALIGNED_SPLIT_EN (word-crossing loads split into two dmem beats).
module load_align_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_fault
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // Keep the low 8*2^sz bits of v and sign/zero-extend them to DATA_W.
    function automatic logic [DATA_W-1:0] extend_f(input logic [DATA_W-1:0] v,
                                                   input logic [1:0] sz,
                                                   input logic uns);
        logic [7:0]        sh;
        logic [DATA_W-1:0] r;
        sh = 8'(DATA_W) - (8'd8 << sz);
        r  = v << sh;
        if (uns) begin
            r = r >> sh;
        end else begin
            r = $unsigned($signed(r) >>> sh);
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_fault_q, rsp_fault_d;

    logic [OFF_W-1:0]    req_off_s;
    logic [3:0]          req_n_s;
    logic                req_fault_s;
    logic [OFF_W+2:0]    sh0_s;
    logic [DATA_W-1:0]   beat0_s;

    assign req_off_s = req_addr[OFF_W-1:0];
    assign req_n_s   = 4'd1 << req_size;
    assign sh0_s     = {off_q, 3'b000};
    assign beat0_s   = dmem_rdata >> sh0_s;

`ifdef MISALIGNED_SPLIT_EN
    logic [DATA_W-1:0]   beat0_q, beat0_d;
    logic [4:0]          end_s;
    logic                cross_s;
    logic [OFF_W:0]      rem_s;
    logic [OFF_W+3:0]    sh1_s;
    logic [DATA_W-1:0]   beat1_s;

    assign req_fault_s = (DATA_W == 32) && (req_size == 2'd3);
    assign end_s       = 5'(off_q) + 5'(4'd1 << size_q);
    assign cross_s     = end_s > 5'(BYTES);
    assign rem_s       = (OFF_W+1)'(BYTES) - {1'b0, off_q};
    assign sh1_s       = {rem_s, 3'b000};
    assign beat1_s     = dmem_rdata << sh1_s;
`else
    assign req_fault_s = ((DATA_W == 32) && (req_size == 2'd3)) ||
                         ((req_off_s & OFF_W'(req_n_s - 4'd1)) != {OFF_W{1'b0}});
`endif

    // Next-state and datapath capture for the load sequencer.
    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        tag_d       = tag_q;
        dmem_addr_d = dmem_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
`ifdef MISALIGNED_SPLIT_EN
        beat0_d     = beat0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d  = req_off_s;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    tag_d  = req_tag;
                    if (req_fault_s) begin
                        rsp_fault_d = 1'b1;
                        rsp_data_d  = {DATA_W{1'b0}};
                        state_d     = S_RESP;
                    end else begin
                        rsp_fault_d = 1'b0;
                        dmem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        state_d     = S_REQ0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ0: begin
                if (dmem_req_ready) begin
                    state_d = S_WAIT0;
                end else begin
                    state_d = S_REQ0;
                end
            end
            S_WAIT0: begin
                if (dmem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
                    if (cross_s) begin
                        beat0_d     = beat0_s;
                        dmem_addr_d = dmem_addr_q + ADDR_W'(BYTES);
                        state_d     = S_REQ1;
                    end else begin
                        rsp_data_d = extend_f(beat0_s, size_q, uns_q);
                        state_d    = S_RESP;
                    end
`else
                    rsp_data_d = extend_f(beat0_s, size_q, uns_q);
                    state_d    = S_RESP;
`endif
                end else begin
                    state_d = S_WAIT0;
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            S_REQ1: begin
                if (dmem_req_ready) begin
                    state_d = S_WAIT1;
                end else begin
                    state_d = S_REQ1;
                end
            end
            S_WAIT1: begin
                if (dmem_rvalid) begin
                    rsp_data_d = extend_f(beat0_q | beat1_s, size_q, uns_q);
                    state_d    = S_RESP;
                end else begin
                    state_d = S_WAIT1;
                end
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            off_q       <= {OFF_W{1'b0}};
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            tag_q       <= {TAG_W{1'b0}};
            dmem_addr_q <= {ADDR_W{1'b0}};
            rsp_data_q  <= {DATA_W{1'b0}};
            rsp_fault_q <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            beat0_q     <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            tag_q       <= tag_d;
            dmem_addr_q <= dmem_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
`ifdef MISALIGNED_SPLIT_EN
            beat0_q     <= beat0_d;
`endif
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign dmem_req_valid = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign dmem_addr      = dmem_addr_q;
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_data       = rsp_data_q;
    assign rsp_tag        = tag_q;
    assign rsp_fault      = rsp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit (DATA_W=32); split-mode cases follow MISALIGNED_SPLIT_EN.
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [4:0]  req_tag;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        rsp_fault;

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int dv_cnt = 0;

    load_align_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_tag(req_tag),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_req_valid && dmem_req_ready) rd_cnt <= rd_cnt + 1;
        if (dmem_req_valid) dv_cnt <= dv_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [4:0] tg);
        req_valid = 1'b1; req_addr = a; req_size = sz; req_unsigned = u; req_tag = tg;
    endtask

    // Aligned/one-beat load at minimum latency: accept c0, dmem req c1, rvalid c2, rsp c3.
    task automatic load1(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic u,
                         input logic [4:0] tg, input logic [31:0] w, input logic [31:0] exp);
        int rd0;
        rd0 = rd_cnt;
        issue(a, sz, u, tg);
        chk({nm, "_req_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        chk({nm, "_dreq_c1"}, dmem_req_valid, 1);
        chk({nm, "_daddr"}, dmem_addr, {a[31:2], 2'b00});
        step();
        chk({nm, "_dreq_c2"}, dmem_req_valid, 0);
        chk({nm, "_rsp_c2"}, rsp_valid, 0);
        dmem_rvalid = 1'b1; dmem_rdata = w;
        step();
        dmem_rvalid = 1'b0;
        chk({nm, "_rsp_c3"}, rsp_valid, 1);
        chk({nm, "_data"}, rsp_data, exp);
        chk({nm, "_tag"}, rsp_tag, tg);
        chk({nm, "_fault"}, rsp_fault, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({nm, "_rsp_done"}, rsp_valid, 0);
        chk({nm, "_reads"}, rd_cnt - rd0, 1);
    endtask

    // Faulting load: rsp at cycle 1 with zero data and no dmem activity.
    task automatic load_fault(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic [4:0] tg);
        int dv0;
        dv0 = dv_cnt;
        issue(a, sz, 1'b0, tg);
        step();
        req_valid = 1'b0;
        chk({nm, "_rsp_c1"}, rsp_valid, 1);
        chk({nm, "_fault"}, rsp_fault, 1);
        chk({nm, "_data"}, rsp_data, 0);
        chk({nm, "_tag"}, rsp_tag, tg);
        chk({nm, "_dreq"}, dmem_req_valid, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({nm, "_rsp_done"}, rsp_valid, 0);
        chk({nm, "_no_dmem"}, dv_cnt - dv0, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_size = 2'd0; req_unsigned = 1'b0;
        req_tag = 5'd0; dmem_req_ready = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0; rsp_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_dreq", dmem_req_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_fault", rsp_fault, 0);
        chk("rst_daddr", dmem_addr, 0);
        rst_n = 1'b1;
        step();

        load1("lb103", 32'h0000_0103, 2'd0, 1'b0, 5'd3, 32'h80FF_1234, 32'hFFFF_FF80);
        load1("lbu101", 32'h0000_0101, 2'd0, 1'b1, 5'd4, 32'h80FF_1234, 32'h0000_0012);
        load1("lhu102", 32'h0000_0102, 2'd1, 1'b1, 5'd5, 32'h8001_0000, 32'h0000_8001);
        load1("lh102", 32'h0000_0102, 2'd1, 1'b0, 5'd6, 32'h8001_0000, 32'hFFFF_8001);
        load1("lw200", 32'h0000_0200, 2'd2, 1'b0, 5'd7, 32'h1234_5678, 32'h1234_5678);
        load_fault("ld_illegal", 32'h0000_0100, 2'd3, 5'd8);

`ifdef MISALIGNED_SPLIT_EN
        load1("lh101", 32'h0000_0101, 2'd1, 1'b0, 5'd10, 32'h80FF_1234, 32'hFFFF_FF12);
        begin : split_lw
            int rd0;
            rd0 = rd_cnt;
            issue(32'h0000_01FE, 2'd2, 1'b0, 5'd11);
            step();
            req_valid = 1'b0;
            chk("split_daddr0", dmem_addr, 32'h0000_01FC);
            chk("split_dreq0", dmem_req_valid, 1);
            step();
            dmem_rvalid = 1'b1; dmem_rdata = 32'hAABB_CCDD;
            step();
            dmem_rvalid = 1'b0;
            chk("split_dreq1", dmem_req_valid, 1);
            chk("split_daddr1", dmem_addr, 32'h0000_0200);
            chk("split_rsp_early", rsp_valid, 0);
            step();
            dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_3344;
            step();
            dmem_rvalid = 1'b0;
            chk("split_rsp", rsp_valid, 1);
            chk("split_data", rsp_data, 32'h3344_AABB);
            chk("split_fault", rsp_fault, 0);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk("split_reads", rd_cnt - rd0, 2);
        end
`else
        load_fault("lw1FE_mis", 32'h0000_01FE, 2'd2, 5'd12);
        load_fault("lh101_mis", 32'h0000_0101, 2'd1, 5'd13);
`endif

        // Backpressure on every handshake.
        issue(32'h0000_0040, 2'd2, 1'b0, 5'd20);
        dmem_req_ready = 1'b0;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_dreq_hold", dmem_req_valid, 1);
            chk("bp_daddr_hold", dmem_addr, 32'h0000_0040);
            chk("bp_req_ready0", req_ready, 0);
            step();
        end
        dmem_req_ready = 1'b1;
        chk("bp_dreq_acc", dmem_req_valid, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("bp_wait_dreq", dmem_req_valid, 0);
            chk("bp_wait_rsp", rsp_valid, 0);
            chk("bp_wait_ready", req_ready, 0);
            step();
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_BABE;
        step();
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 32'hCAFE_BABE);
            chk("bp_rsp_tag", rsp_tag, 5'd20);
            chk("bp_rsp_ready0", req_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("bp_rsp_done", rsp_valid, 0);
        chk("bp_idle", req_ready, 1);

        // Reset while waiting for read data; the stale rvalid must be ignored.
        issue(32'h0000_0000, 2'd2, 1'b0, 5'd9);
        step();
        req_valid = 1'b0;
        step();
        chk("rw_in_wait", dmem_req_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_ready", req_ready, 1);
        chk("rw_rst_rsp", rsp_valid, 0);
        chk("rw_rst_daddr", dmem_addr, 0);
        chk("rw_rst_tag", rsp_tag, 0);
        step();
        rst_n = 1'b1;
        step();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_rvalid = 1'b0;
        chk("rw_late_rsp", rsp_valid, 0);
        chk("rw_late_ready", req_ready, 1);
        step();
        chk("rw_late_rsp2", rsp_valid, 0);
        load1("lw0", 32'h0000_0000, 2'd2, 1'b0, 5'd1, 32'h0102_0304, 32'h0102_0304);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
